// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter slice.
// Provides the opcode encoding used by the logic-gate blocks, the
// requester ID width and the reset value of the round-robin pointer.
package logic_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  localparam int unsigned ID_W = 2;

  // Pointer resets to the last requester so requester 0 has first priority.
  localparam logic [ID_W-1:0] LAST_GRANT_RST = 2'd3;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter4.sv
// Four-way round-robin grant selector, purely combinational.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the most recently served requester
//   gnt        - one-hot grant (zero when no request)
//   gnt_id     - index of the granted requester (last_grant when none)
module rr_arbiter4
  import logic_unit_arbiter_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [ID_W-1:0] last_grant,
  output logic [3:0]      gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Search starts one past last_grant and wraps; k=4 revisits last_grant itself.
  always_comb begin
    gnt    = '0;
    gnt_id = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_grant + k[ID_W-1:0];
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_id      = idx;
        gnt[idx]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOT)
// between four requesters, with a single registered response port.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   req_valid/ready  - per-requester handshake (ready is combinational)
//   req_op/a/b       - packed per-requester opcode and operands
//   rsp_valid/ready  - response handshake
//   rsp_id, rsp_data - owner and result of the registered response
//   busy             - response pending or any request outstanding
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready,
  output logic                   busy
);

  logic [ID_W-1:0]  last_grant;
  logic [3:0]       gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             can_accept;
  logic             xfer;
  op_e              op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] result;

  rr_arbiter4 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  // Output register can take a new result when empty or being drained;
  // grants are suppressed while reset is asserted.
  assign can_accept = (!rsp_valid || rsp_ready) && !rst;
  assign req_ready  = can_accept ? gnt : '0;
  assign xfer       = |(req_valid & req_ready);
  assign busy       = rsp_valid | (|req_valid);

  always_comb begin
    op_sel = op_e'(req_op[{gnt_id, 1'b0} +: 2]);
    a_sel  = req_a[WIDTH*gnt_id +: WIDTH];
    b_sel  = req_b[WIDTH*gnt_id +: WIDTH];
    result = '0;
    case (op_sel)
      OP_AND:  result = a_sel & b_sel;
      OP_OR:   result = a_sel | b_sel;
      OP_XOR:  result = a_sel ^ b_sel;
      OP_NOT:  result = ~a_sel;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      last_grant <= LAST_GRANT_RST;
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_id;
      rsp_data   <= result;
      last_grant <= gnt_id;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready = 1'b1;
  logic        busy;

  logic_unit_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Reference model: a pointer, an occupancy flag and a queue of expected responses.
  logic [9:0] q[$];
  int         m_lg   = 3;
  bit         m_full = 1'b0;

  initial begin
    int         sel;
    logic [3:0] exp_rdy;
    bit         m_rst, m_rr, m_x;
    logic [9:0] m_item;
    forever begin
      @(negedge clk);
      sel = -1;
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_lg + k) % 4;
        if (sel < 0 && req_valid[i]) sel = i;
      end
      exp_rdy = '0;
      if (!rst && (!m_full || rsp_ready) && sel >= 0) exp_rdy[sel] = 1'b1;
      if (!rst) chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      chk("busy", {31'd0, busy}, {31'd0, (rsp_valid | (|req_valid))});
      m_rst = rst;
      m_rr  = rsp_ready;
      m_x   = (exp_rdy != 0);
      m_item = '0;
      if (m_x) m_item = {sel[1:0], ref_op(req_op[2*sel +: 2], req_a[8*sel +: 8], req_b[8*sel +: 8])};
      @(posedge clk);
      if (m_rst) begin
        q.delete();
        m_full = 1'b0;
        m_lg   = 3;
      end else if (m_x) begin
        q.push_back(m_item);
        m_full = 1'b1;
        m_lg   = sel;
      end else if (m_rr) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: checks presence, stability under stall, and pops on consumption.
  initial begin
    bit         prev_stall = 1'b0;
    logic [9:0] prev_rsp   = '0;
    logic [9:0] item;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (q.size() != 0)});
        if (prev_stall) chk("stall_hold", {22'd0, rsp_id, rsp_data}, {22'd0, prev_rsp});
        if (rsp_valid && rsp_ready && q.size() != 0) begin
          item = q.pop_front();
          chk("rsp", {22'd0, rsp_id, rsp_data}, {22'd0, item});
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = {rsp_id, rsp_data};
      end
    end
  end

  logic [3:0] refill = '0;
  bit         rnd    = 1'b0;

  task automatic new_req(input int i);
    req_valid[i]     = 1'b1;
    req_op[2*i +: 2] = 2'($urandom_range(0, 3));
    req_a[8*i +: 8]  = 8'($urandom_range(0, 255));
    req_b[8*i +: 8]  = 8'($urandom_range(0, 255));
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]     = 1'b1;
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // One clock: accepted requests drop or are replaced; inputs change 2 after the edge.
  task automatic tick(input int n);
    logic [3:0] acc;
    repeat (n) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          if (refill[i]) new_req(i);
          else req_valid[i] = 1'b0;
        end
        if (rnd && !req_valid[i] && $urandom_range(0, 2) == 0) new_req(i);
      end
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [7:0] sweep_exp [4];
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'h0F;

    tick(2);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_data",  {24'd0, rsp_data},  32'd0);
    chk("reset_id",    {30'd0, rsp_id},    32'd0);
    rst = 1'b0;

    // single request from requester 2
    set_req(2, 2'b01, 8'hA0, 8'h05);
    tick(1);
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_id",    {30'd0, rsp_id},    32'd2);
    chk("single_data",  {24'd0, rsp_data},  32'hA5);

    // opcode sweep on requester 0
    for (int op = 0; op < 4; op++) begin
      set_req(0, 2'(op), 8'hF0, 8'h3C);
      tick(1);
      chk("sweep_data", {24'd0, rsp_data}, {24'd0, sweep_exp[op]});
    end

    // all four continuously valid; pointer last served 0, so service starts at 1
    refill = 4'hF;
    for (int i = 0; i < 4; i++) new_req(i);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rr_id", {30'd0, rsp_id}, (k + 1) % 4);
    end

    // backpressure with requesters 1 and 3
    refill    = '0;
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(1, 2'($urandom_range(0, 3)), 8'h5A, 8'hC3);
    set_req(3, 2'($urandom_range(0, 3)), 8'h11, 8'hEE);
    tick(3);
    rsp_ready = 1'b1;
    tick(1);
    chk("bp_first",  {30'd0, rsp_id}, 32'd1);
    tick(1);
    chk("bp_second", {30'd0, rsp_id}, 32'd3);

    // wrap: only requester 3, pointer at 3
    set_req(3, 2'b10, 8'hFF, 8'h0F);
    tick(1);
    chk("wrap_id",   {30'd0, rsp_id},   32'd3);
    chk("wrap_data", {24'd0, rsp_data}, 32'hF0);

    // stalled requester 1 must not rotate priority
    rsp_ready = 1'b0;
    set_req(1, 2'b00, 8'h0F, 8'hFF);
    tick(2);
    rsp_ready = 1'b1;
    set_req(0, 2'b11, 8'h55, 8'h00);
    tick(1);
    chk("hold_first",  {30'd0, rsp_id}, 32'd0);
    tick(1);
    chk("hold_second", {30'd0, rsp_id}, 32'd1);

    // reset while stalled
    rsp_ready = 1'b0;
    tick(1);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    refill    = 4'hF;
    for (int i = 0; i < 4; i++) new_req(i);
    tick(1);
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_data",  {24'd0, rsp_data},  32'd0);
    tick(1);
    chk("rst_mid_first", {30'd0, rsp_id}, 32'd0);
    tick(3);

    // random traffic with random backpressure
    refill = '0;
    rnd    = 1'b1;
    tick(400);
    rnd       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(3);
    chk("drain_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
